// File: rtl/exception_pc_ctrl.sv
// Exception sequencer for the multicycle datapath PC-source mux.
// On an exception it saves the return PC, reads the handler byte from the
// vector table and issues one PC load through select 00; on a return request
// it issues one PC load through select 01 using the saved PC.
module exception_pc_ctrl #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned VEC_BASE    = 253
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic        rte_req,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] epc_out,
    output logic [31:0] exception_destiny,
    output logic [1:0]  pc_source_ctrl,
    output logic        pc_write,
    output logic [1:0]  cause,
    output logic        in_handler,
    output logic        busy
);

    localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [1:0] SrcHandler = 2'b00;
    localparam logic [1:0] SrcEpc     = 2'b01;
    localparam logic [1:0] SrcIdle    = 2'b10;

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StJump, StRte} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              exc_any;
    logic [1:0]        cause_sel;
    logic [31:0]       vec_addr;

    assign exc_any = exc_opcode | exc_overflow | exc_div0;
    assign busy    = (state_q != StIdle);

    // Fixed-priority cause encoding: opcode > overflow > div0.
    always_comb begin
        cause_sel = 2'd2;
        if (exc_opcode) begin
            cause_sel = 2'd0;
        end else if (exc_overflow) begin
            cause_sel = 2'd1;
        end
    end

    assign vec_addr = 32'(VEC_BASE) + {30'b0, cause_sel};

    // Sequencer state, latched exception context and registered mux controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            epc_out           <= '0;
            exception_destiny <= '0;
            cause             <= 2'd0;
            in_handler        <= 1'b0;
            mem_rd            <= 1'b0;
            mem_addr          <= '0;
            pc_write          <= 1'b0;
            pc_source_ctrl    <= SrcIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (exc_any) begin
                        // An exception always beats a concurrent return request.
                        cause    <= cause_sel;
                        epc_out  <= pc_in - 32'd4;
                        cnt_q    <= '0;
                        mem_rd   <= 1'b1;
                        mem_addr <= vec_addr;
                        state_q  <= StFetch;
                    end else if (rte_req) begin
                        pc_write       <= 1'b1;
                        pc_source_ctrl <= SrcEpc;
                        state_q        <= StRte;
                    end
                end
                StFetch: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(MEM_LATENCY - 1)) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    exception_destiny <= {24'b0, mem_data};
                    mem_rd            <= 1'b0;
                    mem_addr          <= '0;
                    pc_write          <= 1'b1;
                    pc_source_ctrl    <= SrcHandler;
                    state_q           <= StJump;
                end
                StJump: begin
                    in_handler     <= 1'b1;
                    pc_write       <= 1'b0;
                    pc_source_ctrl <= SrcIdle;
                    state_q        <= StIdle;
                end
                StRte: begin
                    in_handler     <= 1'b0;
                    pc_write       <= 1'b0;
                    pc_source_ctrl <= SrcIdle;
                    state_q        <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/exception_pc_ctrl.md
# exception_pc_ctrl

Exception sequencer that drives the PC-source select and the two exception-side data inputs of the PC source mux: the handler target (select 00) and the saved return address (select 01). It sits beside the main control unit in the multicycle datapath. On an exception it captures the EPC and reads the handler address byte from the memory vector table. It then issues a single PC write through select 00. On a return-from-exception request it issues a single PC write through select 01.

## Interface
Parameters:
- MEM_LATENCY, 2, memory read latency in cycles (must be ≥1); length of FETCH.
- VEC_BASE, 253, byte address of the first vector-table entry.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- exc_opcode  input  1  invalid-opcode exception request (level, sampled in IDLE).
- exc_overflow  input  1  ALU overflow exception request.
- exc_div0  input  1  divide-by-zero exception request.
- rte_req  input  1  return-from-exception request.
- pc_in  input  32  current PC (already incremented by 4).
- mem_data  input  8  byte returned by memory for mem_addr.
- mem_addr  output  32  vector-table read address.
- mem_rd  output  1  memory read enable.
- epc_out  output  32  saved exception PC (mux input 01).
- exception_destiny  output  32  handler address (mux input 00).
- pc_source_ctrl  output  2  PC mux select.
- pc_write  output  1  one-cycle PC load strobe.
- cause  output  2  latched cause: 0 opcode, 1 overflow, 2 div0.
- in_handler  output  1  set on handler entry; cleared on RTE.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, FETCH, LOAD, JUMP, RTE.
- **IDLE, any exception request high:**
  - Latch cause. Priority is opcode > overflow > div0.
  - epc_out <= pc_in − 4, modulo 2^32.
  - Go to FETCH. Clear the latency counter.
- **IDLE, rte_req high and no exception request:** go to RTE. An exception always wins over rte_req.
- **FETCH:**
  - mem_rd = 1; mem_addr = VEC_BASE + cause, zero-extended to 32 bits.
  - Counter increments each cycle.
  - After MEM_LATENCY cycles, go to LOAD.
- **LOAD:**
  - mem_rd and mem_addr are held.
  - exception_destiny <= {24'b0, mem_data}.
  - Go to JUMP.
- **JUMP:**
  - pc_source_ctrl = 2'b00, pc_write = 1.
  - in_handler <= 1. Go to IDLE.
- **RTE:**
  - pc_source_ctrl = 2'b01, pc_write = 1.
  - in_handler <= 0. Go to IDLE.
- **Idle outputs:** outside JUMP/RTE, pc_source_ctrl = 2'b10 and pc_write = 0. Outside FETCH/LOAD, mem_rd = 0 and mem_addr = 0.
- **Requests while busy:** exception and rte requests arriving when not in IDLE are ignored, not queued. epc_out, cause and exception_destiny keep their values.
- **Nested exception:** an exception while in_handler = 1 is accepted. It overwrites epc_out and cause.
- **rte_req with in_handler = 0:** still executes RTE, using the current epc_out.

## Timing
- **Reset values** (asynchronous, while reset_n = 0):
  - state = IDLE.
  - epc_out = 0, exception_destiny = 0, cause = 0, in_handler = 0.
  - mem_rd = 0, mem_addr = 0.
  - pc_write = 0, pc_source_ctrl = 2'b10, busy = 0.
- **Exception latency:**
  - The exception is sampled at edge E0.
  - FETCH covers cycles E0..E0+MEM_LATENCY.
  - LOAD is the cycle after E0+MEM_LATENCY.
  - pc_write is high for exactly the one cycle following edge E0+MEM_LATENCY+1.
  - With MEM_LATENCY = 2, the PC loads at edge E0+4.
- **mem_data sampling:** mem_data is sampled at the edge ending LOAD, i.e. MEM_LATENCY+1 cycles after mem_rd first rises.
- **RTE latency:** rte_req is sampled at E0. pc_write and select 01 are high during the next cycle only.
- **Output hold:** epc_out updates at E0 and is stable through RTE. exception_destiny is stable from LOAD's closing edge until the next exception.
- **Reset mid-sequence:** returns to IDLE at once. No pc_write is issued; all registers take their reset values.
- **Back-to-back requests:** a new request can be accepted on the edge immediately after JUMP or RTE.

## Test plan
- **Invalid opcode:** reset, pc_in = 0x00000010, exc_opcode pulse, memory returns 0x5C at addr 253 -> epc_out = 0x0000000C; mem_addr = 253 with mem_rd = 1 for 3 cycles; exception_destiny = 0x0000005C; pc_write with select 00 one cycle, 4 cycles after the request; in_handler = 1.
- **Simultaneous exceptions:** exc_overflow, exc_div0 and rte_req all high -> cause = 1, mem_addr = 254, no RTE strobe.
- **EPC wrap-around:** exc_div0 with pc_in = 0x00000000 -> epc_out = 0xFFFFFFFC, mem_addr = 255.
- **RTE:** after the first scenario, rte_req -> pc_source_ctrl = 01 and pc_write = 1 for one cycle; epc_out unchanged; in_handler = 0.
- **Requests while busy:** exc_opcode held during FETCH -> ignored; exactly one pc_write; cause unchanged. Then reset_n = 0 during LOAD -> immediate reset values; no pc_write afterwards.
- **Latency parameter:** MEM_LATENCY = 1, exc_overflow -> mem_rd high 2 cycles; pc_write 3 cycles after the request.
